// File: rtl/coef_pkg.sv
// rtl/coef_pkg.sv - shared types and defaults for the coefficient frame bank
package coef_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_N_ZERO = 4;
  localparam int DEF_N_POLE = 4;
  localparam int GEN_W      = 8;

endpackage

// File: rtl/coef_frame_bank_if.sv
// rtl/coef_frame_bank_if.sv - coefficient write handshake bus
interface coef_wr_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/coef_bank_regs.sv
// rtl/coef_bank_regs.sv - N x DATA_W register array, word write port plus bulk load
module coef_bank_regs #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int AW     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                load_i,
  input  logic [N*DATA_W-1:0] load_data_i,
  output logic [N*DATA_W-1:0] q_o
);
  logic [N*DATA_W-1:0] bank_q, bank_d;

  // Bulk load wins over a word write so a swap is always atomic.
  always_comb begin
    bank_d = bank_q;
    if (load_i) begin
      bank_d = load_data_i;
    end else if (we_i) begin
      for (int k = 0; k < N; k++) begin
        if (waddr_i == AW'(k)) bank_d[k*DATA_W +: DATA_W] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bank_q <= '0;
    else          bank_q <= bank_d;
  end

  assign q_o = bank_q;
endmodule

// File: rtl/coef_frame_bank.sv
// rtl/coef_frame_bank.sv - double-buffered zero/pole coefficient bank, swap on frame_done
// Optional readback port enabled by COEF_READBACK_EN.
module coef_frame_bank
  import coef_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_ZERO = DEF_N_ZERO,
  parameter int N_POLE = DEF_N_POLE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_done,
  coef_wr_if.slave                 wr,
  input  logic                     commit_req,
  output logic                     armed,
  output logic                     applied,
  output logic                     commit_err,
  output logic                     wr_err,
  output logic [GEN_W-1:0]         bank_gen,
`ifdef COEF_READBACK_EN
  input  logic                     rd_en,
  input  logic [$clog2(N_ZERO+N_POLE)-1:0] rd_addr,
  input  logic                     rd_sel,
  output logic [DATA_W-1:0]        rd_data,
`endif
  output logic [N_ZERO*DATA_W-1:0] zero_out,
  output logic [N_POLE*DATA_W-1:0] pole_out
);
  localparam int N      = N_ZERO + N_POLE;
  localparam int ADDR_W = $clog2(N);

  state_e             state_q, state_d;
  logic [N-1:0]       mask_q, mask_d, mask_wr, addr_oh;
  logic [GEN_W-1:0]   gen_q, gen_d;
  logic               applied_q, commit_err_q, commit_err_d, wr_err_q;
  logic               wr_fire, in_range, sh_we, swap;
  logic [N*DATA_W-1:0] shadow_q, active_q;

  always_comb begin
    state_d      = state_q;
    commit_err_d = 1'b0;
    wr_fire      = wr.wr_valid && (state_q == ST_IDLE);
    in_range     = int'(wr.wr_addr) < N;
    sh_we        = wr_fire && in_range;
    addr_oh      = N'(1) << wr.wr_addr;
    // A write in the same cycle as commit_req counts toward completeness.
    mask_wr      = sh_we ? (mask_q | addr_oh) : mask_q;
    swap         = (state_q == ST_ARMED) && frame_done;
    mask_d       = swap ? '0 : mask_wr;
    gen_d        = gen_q + GEN_W'(swap);
    case (state_q)
      ST_IDLE: begin
        if (commit_req) begin
          if (&mask_wr) state_d = ST_ARMED;
          else          commit_err_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (frame_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      gen_q        <= '0;
      applied_q    <= 1'b0;
      commit_err_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      gen_q        <= gen_d;
      applied_q    <= swap;
      commit_err_q <= commit_err_d;
      wr_err_q     <= wr_fire && !in_range;
    end
  end

  coef_bank_regs #(.N(N), .DATA_W(DATA_W), .AW(ADDR_W)) u_shadow (
    .clk(clk), .reset_n(reset_n), .we_i(sh_we), .waddr_i(wr.wr_addr),
    .wdata_i(wr.wr_data), .load_i(1'b0), .load_data_i('0), .q_o(shadow_q)
  );

  coef_bank_regs #(.N(N), .DATA_W(DATA_W), .AW(ADDR_W)) u_active (
    .clk(clk), .reset_n(reset_n), .we_i(1'b0), .waddr_i('0),
    .wdata_i('0), .load_i(swap), .load_data_i(shadow_q), .q_o(active_q)
  );

`ifdef COEF_READBACK_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int k = 0; k < N; k++) begin
        if (rd_addr == ADDR_W'(k))
          rd_data_d = rd_sel ? shadow_q[k*DATA_W +: DATA_W] : active_q[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

  assign wr.wr_ready = (state_q == ST_IDLE);
  assign armed       = (state_q == ST_ARMED);
  assign applied     = applied_q;
  assign commit_err  = commit_err_q;
  assign wr_err      = wr_err_q;
  assign bank_gen    = gen_q;
  assign zero_out    = active_q[N_ZERO*DATA_W-1:0];
  assign pole_out    = active_q[N*DATA_W-1:N_ZERO*DATA_W];
endmodule

// File: tb/tb_coef_frame_bank.sv
// tb/tb_coef_frame_bank.sv - self-checking bench for coef_frame_bank
module tb_coef_frame_bank;
  import coef_pkg::*;

  localparam int DW = 32, NZ = 4, NP = 4, N = 8, AW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic frame_done = 1'b0, commit_req = 1'b0;
  logic armed, applied, commit_err, wr_err;
  logic [7:0] bank_gen;
  logic [NZ*DW-1:0] zero_out;
  logic [NP*DW-1:0] pole_out;
`ifdef COEF_READBACK_EN
  logic rd_en = 1'b0, rd_sel = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic s_rd_en = 1'b0, s_rd_sel = 1'b0;
  logic [2:0] s_rd_addr = '0;
  logic [7:0] s_rd_data;
`endif

  coef_wr_if #(.ADDR_W(AW), .DATA_W(DW)) wr ();

  coef_frame_bank #(.DATA_W(DW), .N_ZERO(NZ), .N_POLE(NP)) dut (
    .clk(clk), .reset_n(reset_n), .frame_done(frame_done), .wr(wr.slave),
    .commit_req(commit_req), .armed(armed), .applied(applied),
    .commit_err(commit_err), .wr_err(wr_err), .bank_gen(bank_gen),
`ifdef COEF_READBACK_EN
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
`endif
    .zero_out(zero_out), .pole_out(pole_out)
  );

  // Small instance (3 zeros, 2 poles) so an out-of-range address is representable.
  logic s_frame_done = 1'b0, s_commit_req = 1'b0;
  logic s_armed, s_applied, s_commit_err, s_wr_err;
  logic [7:0] s_bank_gen;
  logic [23:0] s_zero_out;
  logic [15:0] s_pole_out;

  coef_wr_if #(.ADDR_W(3), .DATA_W(8)) swr ();

  coef_frame_bank #(.DATA_W(8), .N_ZERO(3), .N_POLE(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .frame_done(s_frame_done), .wr(swr.slave),
    .commit_req(s_commit_req), .armed(s_armed), .applied(s_applied),
    .commit_err(s_commit_err), .wr_err(s_wr_err), .bank_gen(s_bank_gen),
`ifdef COEF_READBACK_EN
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_sel(s_rd_sel), .rd_data(s_rd_data),
`endif
    .zero_out(s_zero_out), .pole_out(s_pole_out)
  );

  int tests = 0, fails = 0;

  logic [DW-1:0] m_sh [N];
  logic [DW-1:0] m_ac [N];
  bit            m_wr [N];
  bit            m_armed, m_app, m_cerr, m_werr;
  int            m_gen;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    for (int k = 0; k < N; k++) begin
      m_sh[k] = '0; m_ac[k] = '0; m_wr[k] = 1'b0;
    end
    m_armed = 0; m_app = 0; m_cerr = 0; m_werr = 0; m_gen = 0;
  endtask

  task automatic check_all;
    logic [NZ*DW-1:0] ez;
    logic [NP*DW-1:0] ep;
    for (int k = 0; k < NZ; k++) ez[k*DW +: DW] = m_ac[k];
    for (int k = 0; k < NP; k++) ep[k*DW +: DW] = m_ac[NZ+k];
    chk("zero_out", 128'(zero_out), 128'(ez));
    chk("pole_out", 128'(pole_out), 128'(ep));
    chk("bank_gen", 128'(bank_gen), 128'(m_gen));
    chk("armed", 128'(armed), 128'(m_armed));
    chk("wr_ready", 128'(wr.wr_ready), 128'(!m_armed));
    chk("applied", 128'(applied), 128'(m_app));
    chk("commit_err", 128'(commit_err), 128'(m_cerr));
    chk("wr_err", 128'(wr_err), 128'(m_werr));
  endtask

  // One clock: apply the behavioural rules to the inputs seen at the edge, then compare.
  task automatic step;
    bit full;
    @(posedge clk);
    m_app = 0; m_cerr = 0; m_werr = 0;
    if (m_armed) begin
      if (frame_done) begin
        for (int k = 0; k < N; k++) begin
          m_ac[k] = m_sh[k]; m_wr[k] = 1'b0;
        end
        m_gen = (m_gen + 1) % 256;
        m_app = 1; m_armed = 0;
      end
    end else begin
      if (wr.wr_valid) begin
        if (int'(wr.wr_addr) < N) begin
          m_sh[wr.wr_addr] = wr.wr_data; m_wr[wr.wr_addr] = 1'b1;
        end else m_werr = 1;
      end
      if (commit_req) begin
        full = 1;
        for (int k = 0; k < N; k++) if (!m_wr[k]) full = 0;
        if (full) m_armed = 1; else m_cerr = 1;
      end
    end
    #1;
    check_all();
  endtask

  task automatic wr_word(input int a, input logic [DW-1:0] d);
    wr.wr_valid = 1'b1; wr.wr_addr = AW'(a); wr.wr_data = d;
    step();
    wr.wr_valid = 1'b0;
  endtask

  task automatic fill_random;
    for (int a = 0; a < N; a++) wr_word(a, $urandom);
  endtask

  task automatic s_wr(input int a, input logic [7:0] d);
    swr.wr_valid = 1'b1; swr.wr_addr = 3'(a); swr.wr_data = d;
    @(posedge clk); #1;
    swr.wr_valid = 1'b0;
  endtask

  initial begin
    wr.wr_valid = 1'b0; wr.wr_addr = '0; wr.wr_data = '0;
    swr.wr_valid = 1'b0; swr.wr_addr = '0; swr.wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    step();

    // Known pattern: zeros 1..4, poles 5..8, frame_done three cycles after commit.
    for (int a = 0; a < N; a++) wr_word(a, DW'(a + 1));
    commit_req = 1'b1; step(); commit_req = 1'b0;
    step(); step();
    chk("pre_swap_zero", 128'(zero_out), 128'(0));
    frame_done = 1'b1; step(); frame_done = 1'b0;
    chk("zeros_1234", 128'(zero_out), {32'd4, 32'd3, 32'd2, 32'd1});
    chk("poles_5678", 128'(pole_out), {32'd8, 32'd7, 32'd6, 32'd5});
    step();

    // Incomplete bank: commit rejected, frame_done harmless.
    for (int a = 0; a < 7; a++) wr_word(a, $urandom);
    commit_req = 1'b1; step(); commit_req = 1'b0;
    step();
    frame_done = 1'b1; step(); frame_done = 1'b0;

    // Complete the bank, arm, and hold a write across the swap.
    wr_word(7, $urandom);
    commit_req = 1'b1; step(); commit_req = 1'b0;
    wr.wr_valid = 1'b1; wr.wr_addr = 3'd2; wr.wr_data = 32'hAA;
    step(); step(); step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    chk("z2_not_aa", 128'(zero_out[2*DW +: DW] != 32'hAA), 128'(1));
    step();
    wr.wr_valid = 1'b0;
    for (int a = 0; a < N; a++) if (a != 2) wr_word(a, $urandom);
    commit_req = 1'b1; step(); commit_req = 1'b0;
    frame_done = 1'b1; step(); frame_done = 1'b0;
    chk("z2_is_aa", 128'(zero_out[2*DW +: DW]), 128'(32'hAA));

    // Commit and frame_done together: arm only, swap at the next frame_done.
    fill_random();
    commit_req = 1'b1; frame_done = 1'b1; step();
    commit_req = 1'b0; frame_done = 1'b0;
    step();
    frame_done = 1'b1; step(); frame_done = 1'b0;

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      wr.wr_valid = 1'($urandom_range(0, 1));
      wr.wr_addr  = AW'($urandom_range(0, N - 1));
      wr.wr_data  = $urandom;
      commit_req  = ($urandom_range(0, 7) == 0);
      frame_done  = ($urandom_range(0, 5) == 0);
      step();
    end
    wr.wr_valid = 1'b0; commit_req = 1'b0; frame_done = 1'b0;
    step();

    // Reset while armed drops everything immediately.
    fill_random();
    commit_req = 1'b1; step(); commit_req = 1'b0;
    chk("armed_before_rst", 128'(armed), 128'(1));
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();

    // 256 full commits wrap the generation counter.
    for (int i = 0; i < 256; i++) begin
      fill_random();
      commit_req = 1'b1; step(); commit_req = 1'b0;
      frame_done = 1'b1; step(); frame_done = 1'b0;
    end
    chk("gen_wrap", 128'(bank_gen), 128'(0));

    // Small instance: out-of-range writes accepted but discarded.
    s_wr(6, 8'h55);
    chk("s_wr_err_pulse", 128'(s_wr_err), 128'(1));
    @(posedge clk); #1;
    chk("s_wr_err_clear", 128'(s_wr_err), 128'(0));
    for (int a = 0; a < 4; a++) s_wr(a, 8'(a + 1));
    s_wr(5, 8'h77);
    chk("s_wr_err_5", 128'(s_wr_err), 128'(1));
    s_wr(4, 8'h05);
    chk("s_wr_err_4", 128'(s_wr_err), 128'(0));
    s_commit_req = 1'b1; @(posedge clk); #1; s_commit_req = 1'b0;
    chk("s_armed", 128'(s_armed), 128'(1));
    chk("s_commit_err", 128'(s_commit_err), 128'(0));
    s_frame_done = 1'b1; @(posedge clk); #1; s_frame_done = 1'b0;
    chk("s_applied", 128'(s_applied), 128'(1));
    chk("s_zero", 128'(s_zero_out), 128'({8'd3, 8'd2, 8'd1}));
    chk("s_pole", 128'(s_pole_out), 128'({8'd5, 8'd4}));
    // Mask cleared after the swap; out-of-range write must not refill it.
    for (int a = 0; a < 4; a++) s_wr(a, 8'hF0);
    s_wr(7, 8'hEE);
    s_commit_req = 1'b1; @(posedge clk); #1; s_commit_req = 1'b0;
    chk("s_commit_err_partial", 128'(s_commit_err), 128'(1));
    chk("s_not_armed", 128'(s_armed), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
